// File: rtl/serial_receiver_8bits.sv
// ---------------------------------------------------------------------------
// serial_receiver_8bits
//
// Receiving end of the 8-bit shift-register link. Bits arrive MSB first, one
// per cycle whenever sin_valid is high, with arbitrarily long gaps allowed.
// A completed byte moves into a separate output register, so the next frame
// can be shifted in while the consumer still holds dout.
//
// Optional feature (macro PARITY_CHECK_EN):
//   When defined, each frame is 9 bits: 8 data bits followed by one
//   even-parity bit. parity_err reports the XOR of all nine bits and is
//   loaded together with dout. When undefined, frames are 8 bits and the
//   parity_err port does not exist.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   sin         in   serial data bit, sampled only when sin_valid=1
//   sin_valid   in   bit strobe
//   sync        in   synchronous resync: drops partial frame, clears overrun
//   dout_ready  in   consumer accepts dout when high with dout_valid
//   dout        out  [7:0] received byte, stable while dout_valid=1
//   dout_valid  out  dout holds an unconsumed byte
//   busy        out  a frame is partially received
//   overrun     out  sticky: a completed byte was dropped
//   parity_err  out  parity result for the byte in dout (PARITY_CHECK_EN only)
// ---------------------------------------------------------------------------
module serial_receiver_8bits (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  input  logic       sin_valid,
  input  logic       sync,
  input  logic       dout_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       busy,
  output logic       overrun
`ifdef PARITY_CHECK_EN
  ,
  output logic       parity_err
`endif
);

`ifdef PARITY_CHECK_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif

  logic [3:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       accept;
  logic       complete;
  logic       load;
  logic       drop;
  logic [7:0] new_byte;

  // sync wins over sin_valid: a bit presented during sync is not taken.
  assign accept   = sin_valid && !sync;
  assign complete = accept && (bit_cnt == LAST_BIT);
  assign load     = complete && (!dout_valid || dout_ready);
  assign drop     = complete && dout_valid && !dout_ready;
  assign busy     = (bit_cnt != 4'd0);

`ifdef PARITY_CHECK_EN
  // The last bit is parity; all eight data bits are already in shift_reg.
  assign new_byte = shift_reg;
`else
  // The last data bit is still on sin when the frame completes.
  assign new_byte = {shift_reg[6:0], sin};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= 4'd0;
      shift_reg <= 8'h00;
    end else if (sync) begin
      bit_cnt   <= 4'd0;
      shift_reg <= 8'h00;
    end else if (accept) begin
      shift_reg <= {shift_reg[6:0], sin};
      bit_cnt   <= complete ? 4'd0 : bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= 8'h00;
      dout_valid <= 1'b0;
    end else if (load) begin
      dout       <= new_byte;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // A drop can never coincide with sync, since completion requires !sync.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (sync) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= (^shift_reg) ^ sin;
    end
  end
`endif

endmodule

// File: tb/tb_serial_receiver_8bits.sv
// Directed bench for serial_receiver_8bits. Inputs change 1 time unit after
// the rising edge; outputs are checked at that same point.
module tb_serial_receiver_8bits;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       sin_valid;
  logic       sync;
  logic       dout_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       overrun;
`ifdef PARITY_CHECK_EN
  logic       parity_err;
`endif

  int checks   = 0;
  int failures = 0;

  serial_receiver_8bits dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sync       (sync),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .overrun    (overrun)
`ifdef PARITY_CHECK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  // Sends a full frame; dout_ready is forced to rdy_last only on the final
  // (completing) bit and restored afterwards.
  task automatic send_frame(input logic [7:0] b, input logic par,
                            input logic rdy_last);
    logic saved_rdy;
    saved_rdy = dout_ready;
`ifdef PARITY_CHECK_EN
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    dout_ready = rdy_last;
    send_bit(par);
`else
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    dout_ready = rdy_last;
    send_bit(b[0]);
`endif
    dout_ready = saved_rdy;
  endtask

  initial begin
    rst        = 1'b0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    sync       = 1'b0;
    dout_ready = 1'b0;
    #22;
    rst = 1'b1;
    tick();

    check("rst_dout", dout, 8'h00);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    // Reset mid-frame after 3 bits
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("mid_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", dout_valid, 1'b0);
    check("mid_rst_dout", dout, 8'h00);
    check("mid_rst_overrun", overrun, 1'b0);
`ifdef PARITY_CHECK_EN
    check("mid_rst_perr", parity_err, 1'b0);
`endif
    #2;
    rst = 1'b1;
    tick();
    send_frame(8'h5A, 1'b0, 1'b0);
    check("restart_dout", dout, 8'h5A);
    check("restart_valid", dout_valid, 1'b1);
    check("restart_busy", busy, 1'b0);
    dout_ready = 1'b1;
    tick();
    check("consume_valid", dout_valid, 1'b0);
    check("consume_dout", dout, 8'h5A);

    // Basic 0xA5 with consumer always ready
    send_frame(8'hA5, 1'b0, 1'b1);
    check("basic_dout", dout, 8'hA5);
    check("basic_valid", dout_valid, 1'b1);
    tick();
    check("basic_valid_1cyc", dout_valid, 1'b0);
    check("basic_busy", busy, 1'b0);
    dout_ready = 1'b0;

    // Backpressure: second byte dropped
    send_frame(8'h3C, 1'b0, 1'b0);
    check("bp_first_dout", dout, 8'h3C);
    check("bp_first_ovr", overrun, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0);
    check("bp_dout_kept", dout, 8'h3C);
    check("bp_overrun", overrun, 1'b1);
    check("bp_valid", dout_valid, 1'b1);
    tick();
    check("bp_ovr_sticky", overrun, 1'b1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("bp_sync_ovr", overrun, 1'b0);
    check("bp_sync_dout", dout, 8'h3C);
    check("bp_sync_valid", dout_valid, 1'b1);

    // sync has priority over sin_valid, and the handshake still completes
    sync       = 1'b1;
    sin        = 1'b1;
    sin_valid  = 1'b1;
    dout_ready = 1'b1;
    tick();
    sync       = 1'b0;
    sin_valid  = 1'b0;
    dout_ready = 1'b0;
    check("syncpri_busy", busy, 1'b0);
    check("syncpri_valid", dout_valid, 1'b0);
    check("syncpri_dout", dout, 8'h3C);

    // Gaps and resync: 4 junk bits, sync, then 0xFF with random gaps
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    check("gap_busy_pre", busy, 1'b1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("gap_sync_busy", busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick();
      send_bit(1'b1);
      if (i == 4) begin
        repeat (5) tick();
        check("gap_busy_hold", busy, 1'b1);
        check("gap_no_valid", dout_valid, 1'b0);
      end
    end
`ifdef PARITY_CHECK_EN
    send_bit(1'b0);
`endif
    check("gap_dout", dout, 8'hFF);
    check("gap_valid", dout_valid, 1'b1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;

    // Back-to-back: 0x81 completes on the edge that accepts 0x7E
    send_frame(8'h7E, 1'b0, 1'b0);
    check("b2b_first", dout, 8'h7E);
    send_frame(8'h81, 1'b0, 1'b1);
    check("b2b_valid", dout_valid, 1'b1);
    check("b2b_dout", dout, 8'h81);
    check("b2b_overrun", overrun, 1'b0);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("b2b_consumed", dout_valid, 1'b0);

`ifdef PARITY_CHECK_EN
    dout_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1);
    check("par_ok_dout", dout, 8'hA5);
    check("par_ok_err", parity_err, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b1);
    check("par_bad_dout", dout, 8'hA5);
    check("par_bad_err", parity_err, 1'b1);
    check("par_bad_valid", dout_valid, 1'b1);
    dout_ready = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_receiver_8bits.md
SERIAL_RECEIVER_8BITS -- requirements
Module: serial_receiver_8bits

Interface
REQ-001 Parameters SHALL be none; the byte width SHALL be fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge except reset.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 sin  input  1  serial data bit; SHALL be sampled only when sin_valid=1.
REQ-005 sin_valid  input  1  bit strobe; one accepted bit per cycle when high.
REQ-006 sync  input  1  synchronous frame resync; SHALL discard any partial frame and clear overrun.
REQ-007 dout_ready  input  1  consumer accepts dout when high together with dout_valid.
REQ-008 dout  output  8  received byte, held stable while dout_valid=1.
REQ-009 dout_valid  output  1  dout holds an unconsumed byte.
REQ-010 busy  output  1  high while a frame is partially received (bit counter nonzero).
REQ-011 overrun  output  1  sticky flag: a completed byte was dropped.
REQ-012 parity_err  output  1  present only with PARITY_CHECK_EN; parity result for the byte in dout.

Function
REQ-013 The block SHALL be the receiving end of the team's 8-bit shift-register transmitter: MSB first; the first accepted bit SHALL land in dout[7].
REQ-014 Each accepted bit SHALL shift the internal register left and insert sin at bit 0, and SHALL increment a bit counter (0..7, or 0..8 with parity).
REQ-015 The shift register and output register SHALL be separate, so a new frame can be received while dout waits.
REQ-016 On the edge that accepts the last data bit (no parity) or the parity bit (with parity), the counter SHALL wrap to 0 and the frame SHALL complete.
REQ-017 On completion with dout_valid=0, or dout_valid=1 and dout_ready=1 on the same edge, dout SHALL load the new byte and dout_valid SHALL be 1 after that edge (zero-cycle latency after the last bit).
REQ-018 On completion with dout_valid=1 and dout_ready=0, the new byte SHALL be dropped, dout SHALL be unchanged, and overrun SHALL set.
REQ-019 dout_valid=1 and dout_ready=1 with no completion SHALL clear dout_valid on that edge; dout SHALL keep its last value.
REQ-020 sin_valid=0 cycles SHALL hold the counter and shift register; gaps between bits SHALL be unlimited.
REQ-021 sync=1 SHALL have priority over sin_valid in the same cycle: the counter clears, the bit is not accepted, and overrun clears; dout, dout_valid and parity_err SHALL be unaffected, and a dout_ready handshake on that edge SHALL still complete.
REQ-022 overrun SHALL stay set until sync or reset.

Reset
REQ-023 rst=0 SHALL immediately force dout=0x00, dout_valid=0, busy=0, overrun=0, parity_err=0, bit counter=0, and shift register=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; after release, reception SHALL restart at the first bit.

Configuration
REQ-025 Macro PARITY_CHECK_EN defined: the frame SHALL be 9 bits (8 data plus 1 even-parity bit), parity_err SHALL be computed as the XOR of the 8 data bits and the parity bit, and parity_err SHALL load with dout.
REQ-026 A byte with a parity error SHALL still be delivered; drop and overrun rules SHALL apply unchanged.
REQ-027 Macro PARITY_CHECK_EN undefined: the frame SHALL be 8 bits, and the parity_err port and its logic SHALL be absent.

Verification
REQ-028 Reset: assert rst mid-frame after 3 bits -> all outputs 0 immediately; the next 8 bits 0x5A -> dout=0x5A.
REQ-029 Basic: bits 1,0,1,0,0,1,0,1 with dout_ready=1 -> dout=0xA5, dout_valid high exactly 1 cycle, busy low afterwards.
REQ-030 Backpressure: dout_ready=0, frames 0x3C then 0xC3 -> dout stays 0x3C, overrun=1; pulse sync -> overrun=0 and dout still 0x3C.
REQ-031 Gaps and resync: 4 bits, sync, then 8 bits of 1 with random sin_valid gaps -> dout=0xFF.
REQ-032 Back-to-back: frame 0x81 completes on the same edge that dout_ready accepts 0x7E -> dout_valid stays 1, dout=0x81, overrun=0.
REQ-033 Parity (PARITY_CHECK_EN): 0xA5 followed by parity bit 0 -> parity_err=0; 0xA5 followed by parity bit 1 -> parity_err=1, dout=0xA5.
